// File: rtl/fir_pkg.sv
// Shared constants, types and state encoding for the 8-lane FIR MAC slice.
package fir_pkg;
  localparam int unsigned FIR_DW    = 18;
  localparam int unsigned FIR_LANES = 8;
  localparam int unsigned FIR_NADDR = 2048;
  localparam int unsigned FIR_AW    = 11;

  // Headroom for 8 lanes (3 bits) times 2**aw addresses on top of a full product.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned aw);
    return 2 * dw + 3 + aw;
  endfunction

  typedef logic signed [FIR_DW-1:0]                      sample_t;
  typedef logic signed [FIR_DW-1:0]                      coef_t;
  typedef logic signed [acc_width(FIR_DW, FIR_AW)-1:0]   acc_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/fir_mult_tree8.sv
// Eight registered signed multipliers (stage M) feeding a registered adder tree (stage T).
module fir_mult_tree8 import fir_pkg::*; #(
  parameter int unsigned DW    = FIR_DW,
  parameter int unsigned ACC_W = acc_width(FIR_DW, FIR_AW)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [FIR_LANES*DW-1:0] a,
  input  logic [FIR_LANES*DW-1:0] b,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic signed [ACC_W-1:0] sum,
  output logic                    out_valid,
  output logic                    out_last
);
  localparam int unsigned PW = 2 * DW;

  logic signed [PW-1:0]    prod [FIR_LANES];
  logic signed [ACC_W-1:0] tree;
  logic                    m_valid;
  logic                    m_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIR_LANES; i++) prod[i] <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      // Lane 0 sits in the most significant slice of both buses.
      for (int unsigned i = 0; i < FIR_LANES; i++)
        prod[i] <= PW'($signed(a[(FIR_LANES-i)*DW-1 -: DW])) *
                   PW'($signed(b[(FIR_LANES-i)*DW-1 -: DW]));
      m_valid <= in_valid;
      m_last  <= in_last;
    end
  end

  always_comb begin
    tree = '0;
    for (int unsigned i = 0; i < FIR_LANES; i++) tree = tree + ACC_W'(prod[i]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      sum       <= tree;
      out_valid <= m_valid;
      out_last  <= m_last;
    end
  end
endmodule

// File: rtl/fir_mac8_seq.sv
// Sweeps the 8-lane sample buffer once per enxk strobe and emits one filtered sample.
// Define FIR_OUT_SAT_EN to clamp the output instead of wrapping it.
module fir_mac8_seq import fir_pkg::*; #(
  parameter int unsigned NADDR     = FIR_NADDR,
  parameter int unsigned AW        = FIR_AW,
  parameter int unsigned DW        = FIR_DW,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ACC_W     = acc_width(DW, AW),
  parameter int unsigned OUT_SHIFT = 17
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enxk,
  output logic [AW-1:0]           addrout,
  input  logic [FIR_LANES*DW-1:0] rdata,
  input  logic [FIR_LANES*DW-1:0] cdata,
  output logic [DW-1:0]           yout,
  output logic                    yvalid,
  output logic                    busy,
  output logic                    overrun
);
  state_t                  state, state_nx;
  logic                    start, issue, fin, last_addr;
  logic [RD_LAT-1:0]       vd, ld;
  logic signed [ACC_W-1:0] tsum, acc;
  logic                    t_valid, t_last;
  logic [DW-1:0]           ynext;

  assign last_addr = (addrout == AW'(NADDR - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enxk) state_nx = RUN;
      RUN:     if (last_addr) state_nx = DRAIN;
      DRAIN:   if (t_valid && t_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start = (state == IDLE) && enxk;
    issue = (state == RUN);
    fin   = (state == DONE);
    busy  = (state != IDLE);
  end

  // Tag each issued address so the final term can be recognised at stage T.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vd <= '0;
      ld <= '0;
    end else begin
      vd[0] <= issue;
      ld[0] <= issue && last_addr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vd[i] <= vd[i-1];
        ld[i] <= ld[i-1];
      end
    end
  end

  fir_mult_tree8 #(.DW(DW), .ACC_W(ACC_W)) u_tree (
    .clock    (clock),
    .reset    (reset),
    .a        (rdata),
    .b        (cdata),
    .in_valid (vd[RD_LAT-1]),
    .in_last  (ld[RD_LAT-1]),
    .sum      (tsum),
    .out_valid(t_valid),
    .out_last (t_last)
  );

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [ACC_W-1:0] YMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] YMIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> OUT_SHIFT;
    if (shifted > YMAX)      ynext = YMAX[DW-1:0];
    else if (shifted < YMIN) ynext = YMIN[DW-1:0];
    else                     ynext = shifted[DW-1:0];
  end
`else
  always_comb ynext = DW'(acc >>> OUT_SHIFT);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addrout <= '0;
      acc     <= '0;
      yout    <= '0;
      yvalid  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      yvalid <= fin;
      if (start)                   addrout <= '0;
      else if (issue && !last_addr) addrout <= addrout + AW'(1);
      if (start)        acc <= '0;
      else if (t_valid) acc <= acc + tsum;
      if (fin) yout <= ynext;
      if (enxk && busy) overrun <= 1'b1;
    end
  end
endmodule

// File: doc/fir_mac8_seq.md
Name: fir_mac8_seq

Overview:
- Downstream consumer of the 8-lane circular sample buffer (RAM_cb_top_8).
- On each sample strobe enxk it sweeps all buffer addresses, one per clock, and reads 8 packed 18-bit samples per address.
- It multiplies each sample by the matching coefficient from the coefficient ROM, addressed in lockstep, and accumulates 8*NADDR products.
- It emits one 18-bit filtered output per strobe.

Parameters:
- NADDR, 2048, addresses swept per output (buffer depth / 8).
- AW, 11, address width; NADDR must be <= 2**AW.
- DW, 18, sample and coefficient width, signed two's complement.
- RD_LAT, 1, clocks from address presentation to valid rdata/cdata.
- ACC_W, 50, accumulator width = 2*DW + 3 + AW.
- OUT_SHIFT, 17, arithmetic right shift applied to the accumulator before output.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enxk  in  1  one-clock sample strobe from the input sampler; starts a sweep.
- addrout  out  AW  read address to the buffer addrin and the coefficient ROM.
- rdata  in  8*DW  buffer data; lane0 = [8*DW-1 -: DW] ... lane7 = [DW-1:0].
- cdata  in  8*DW  coefficient data, same lane packing as rdata.
- yout  out  DW  filtered output sample, signed.
- yvalid  out  1  one-clock pulse when yout updates.
- busy  out  1  high from sweep start until yvalid.
- overrun  out  1  sticky flag: enxk arrived while busy.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; addrout=0, yout=0, yvalid=0, busy=0, overrun=0; accumulator and all pipeline registers = 0, pipeline valid bits = 0.
- IDLE: enxk=1 sampled at cycle 0 -> clear accumulator, go to RUN, busy=1 from cycle 1.
- RUN: addrout=0 at cycle 1, incremented by 1 each clock; addrout=NADDR-1 at cycle NADDR, then go to DRAIN. addrout holds its last value outside RUN.
- Pipeline per address, with tag valid bit:
  - data at +RD_LAT;
  - stage M registers the 8 full products (2*DW bits each) at +RD_LAT+1;
  - stage T registers the sign-extended adder-tree sum at +RD_LAT+2;
  - stage A adds T into the accumulator at +RD_LAT+3.
- DRAIN: waits until the last tagged term is accumulated, then goes to DONE.
- DONE (one clock): yout <= sat_or_wrap(acc >>> OUT_SHIFT); yvalid=1 for exactly one clock; busy drops the same cycle; return to IDLE.
- Latency: yvalid asserts exactly NADDR+RD_LAT+4 clocks after the enxk sample edge.
- Arithmetic: all signed; products sign-extended to ACC_W before summing; the accumulator cannot overflow by construction.
- enxk while busy (including the DONE cycle): ignored; overrun<=1 and held until reset.
- enxk coincident with reset asserted: ignored.
- NADDR < 2**AW: addrout never exceeds NADDR-1.
- Reset mid-sweep: immediate abort, no yvalid, outputs return to reset values.

Optional Feature:
- FIR_OUT_SAT_EN defined: shifted accumulator clamped to [-2**(DW-1), 2**(DW-1)-1].
- Not defined: yout = low DW bits of the shifted accumulator (wrap).

Decomposition:
- Package fir_pkg: DW, lane count 8, default NADDR/AW, ACC_W derivation function, sample_t/coef_t/acc_t signed typedefs, state enum {IDLE,RUN,DRAIN,DONE}.
- Sub-module fir_mult_tree8: 8 registered multipliers plus registered adder tree (stages M and T) with valid pass-through.
- Sequencer FSM and accumulator live in the top.

Test Plan:
- NADDR=2048, OUT_SHIFT=0, all rdata lanes=1, all cdata lanes=1, one enxk -> yvalid once at cycle 2053 (RD_LAT=1), yout=16384, busy low after.
- rdata lanes=1, lane0 coefficient=-2, others 0, OUT_SHIFT=0 -> yout=-4096.
- rdata=131071 and cdata=131071 on all lanes, OUT_SHIFT=0:
  - with FIR_OUT_SAT_EN -> yout=131071;
  - without -> yout = low 18 bits of 16384*131071^2.
- Second enxk at cycle 500 of a sweep -> ignored, overrun=1, single yvalid, result unchanged.
- reset driven low at cycle 1000 of a sweep, then released, new enxk -> no yvalid from the aborted sweep; the new sweep gives the correct result.
- Back-to-back strobes every 2083 clocks for 4 strobes with an incrementing buffer model -> four yvalid pulses, overrun stays 0, addrout sequence 0..2047 each sweep.
